// File: rtl/divider.sv
// divider -- iterative restoring integer divider with RISC-V M semantics.
//
// Performs DIV / DIVU / REM / REMU on WIDTH-bit operands, one quotient bit
// per clock. An accepted request spends WIDTH cycles in CALC and one cycle
// in FIX (sign correction), then presents a registered result with a
// one-cycle valid pulse.
//
// Ports:
//   clk     in   1      clock, rising edge
//   rst     in   1      asynchronous active-high reset
//   start   in   1      request, sampled only while idle
//   op      in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a       in   WIDTH  dividend, sampled with start
//   b       in   WIDTH  divisor, sampled with start
//   kill    in   1      flush: abandon the operation in flight
//   busy    out  1      operation in progress (start ignored)
//   valid   out  1      one-cycle result-valid pulse
//   result  out  WIDTH  quotient or remainder selected by op
//
// Build option:
//   DIV_ZERO_BYPASS_EN  when defined, a request with b == 0 skips CALC and
//                       goes straight to FIX, giving a 2-cycle latency.
//                       Result values are the same either way.

module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             signDiff_q, signDiff_d;
  logic             aSign_q, aSign_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;

  logic             signedOp;
  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   sub;
  logic             ge;
  logic [WIDTH-1:0] quoFinal;
  logic [WIDTH-1:0] remFinal;

  // Operand preparation: signed ops work on magnitudes, unsigned on raw bits.
  // Negating -2^(WIDTH-1) yields itself, which is the correct unsigned
  // magnitude, so the overflow case needs no special handling.
  always_comb begin
    signedOp = ~op[0];
    aNeg     = signedOp & a[WIDTH-1];
    bNeg     = signedOp & b[WIDTH-1];
    aMag     = aNeg ? ({WIDTH{1'b0}} - a) : a;
    bMag     = bNeg ? ({WIDTH{1'b0}} - b) : b;
  end

  // One restoring step. The shifted partial remainder is WIDTH+1 bits; it is
  // at least the divisor when its top bit is set or when the WIDTH-bit
  // subtraction does not borrow. The kept difference always fits WIDTH bits.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    sub     = {1'b0, shifted[WIDTH-1:0]} - {1'b0, div_q};
    ge      = shifted[WIDTH] | ~sub[WIDTH];
  end

  // Sign correction applied in FIX. A zero divisor never flips the quotient,
  // so it stays all-ones; the remainder takes the dividend's sign, which
  // makes a zero divisor return the original dividend.
  always_comb begin
    quoFinal = (~op_q[0] & signDiff_q) ? ({WIDTH{1'b0}} - quo_q) : quo_q;
    remFinal = (~op_q[0] & aSign_q)    ? ({WIDTH{1'b0}} - rem_q) : rem_q;
  end

  // Next-state and datapath control. Kill overrides everything at the end so
  // it wins over a simultaneous start and swallows a pending valid.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    signDiff_d = signDiff_q;
    aSign_d    = aSign_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    valid_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !kill) begin
          state_d    = CALC;
          op_d       = op;
          signDiff_d = (a[WIDTH-1] ^ b[WIDTH-1]) & (b != '0);
          aSign_d    = a[WIDTH-1];
          rem_d      = '0;
          quo_d      = aMag;
          div_d      = bMag;
          cnt_d      = CW'(WIDTH - 1);
`ifdef DIV_ZERO_BYPASS_EN
          // Preload what the iteration would converge to for b == 0.
          if (b == '0) begin
            state_d = FIX;
            quo_d   = '1;
            rem_d   = aMag;
          end
`endif
        end
      end

      CALC: begin
        rem_d = ge ? sub[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      FIX: begin
        state_d  = IDLE;
        result_d = op_q[1] ? remFinal : quoFinal;
        valid_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (kill) begin
      state_d  = IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      signDiff_q <= 1'b0;
      aSign_q    <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      signDiff_q <= signDiff_d;
      aSign_q    <= aSign_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign valid  = valid_q;
  assign result = result_q;

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (RISC-V M semantics).
REQ-006 SHALL have port a  input  WIDTH  dividend; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  divisor; sampled with start.
REQ-008 SHALL have port kill  input  1  pipeline flush; abandons the operation in flight.
REQ-009 SHALL have port busy  output  1  operation in progress; start ignored.
REQ-010 SHALL have port valid  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port result  output  WIDTH  quotient or remainder per op.

Function
REQ-012 SHALL implement FSM IDLE -> CALC -> FIX -> IDLE; IDLE to CALC on start & !kill; CALC runs exactly WIDTH cycles; FIX lasts one cycle.
REQ-013 SHALL, on accepting start, latch op, sign flags, |a| and |b| (magnitudes for signed ops; raw for unsigned ops) and clear the partial remainder.
REQ-014 SHALL, each CALC cycle, shift {rem,quo} left one bit, subtract the divisor from the upper WIDTH+1 bits, keep the difference and set quotient bit 1 if non-negative, else restore and set 0 (restoring, one bit/cycle).
REQ-015 SHALL, in FIX, negate the quotient iff signed op, sign(a)!=sign(b) and b!=0; negate the remainder iff signed op and a negative.
REQ-016 SHALL, for b==0, produce quotient all-ones and remainder = a, for both signed and unsigned ops.
REQ-017 SHALL, for DIV/REM with a = -2^(WIDTH-1) and b = -1, produce quotient -2^(WIDTH-1) and remainder 0.
REQ-018 SHALL register result and pulse valid for exactly one cycle, WIDTH+2 cycles after the start-accept edge (34 for WIDTH=32).
REQ-019 SHALL assert busy from the cycle after start acceptance until the valid cycle exclusive; busy is low during the valid cycle, and start is accepted in that cycle.
REQ-020 SHALL ignore start while busy; latched operands are not disturbed.
REQ-021 SHALL, on kill in any state, enter IDLE on the next edge, suppress valid, and leave result unchanged; kill has priority over simultaneous start.
REQ-022 SHALL hold result stable from the valid cycle until the next valid.

Reset
REQ-023 SHALL, on rst asserted, immediately force state IDLE, busy 0, valid 0, result 0, and all internal registers 0, regardless of the clock.
REQ-024 SHALL, on rst asserted mid-operation, discard the operation and never emit its valid.
REQ-025 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-026 SHALL honour macro DIV_ZERO_BYPASS_EN: when defined, start with b==0 skips CALC, goes directly to FIX, and pulses valid 2 cycles after the accept edge, with the REQ-016 values; when undefined, b==0 takes the full WIDTH+2 latency with identical result values.

Verification
REQ-027 SHALL pass: DIVU a=100, b=7 -> valid at +34, result=14; REMU same operands -> result=2.
REQ-028 SHALL pass: DIV a=-100 (0xFFFFFF9C), b=7 -> result=0xFFFFFFF2 (-14); REM same operands -> 0xFFFFFFFE (-2).
REQ-029 SHALL pass: DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000; REM same operands -> 0.
REQ-030 SHALL pass: DIVU a=5, b=0 -> result=0xFFFFFFFF; REM a=-5, b=0 -> result=0xFFFFFFFB; valid at +2 with DIV_ZERO_BYPASS_EN, at +34 without.
REQ-031 SHALL pass: start, kill at +10, new start at +11 (DIVU 9/3) -> single valid, result=3, at +34 from second start.
REQ-032 SHALL pass: start while busy with different operands, and rst at +20 -> no valid for either; outputs 0 immediately on rst.
